// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared FSM encodings and status constants for the iterative divider
package div_unit_pkg;

    localparam logic [1:0] DIV_FREE   = 2'b00;
    localparam logic [1:0] DIV_BYZERO = 2'b01;
    localparam logic [1:0] DIV_ON     = 2'b10;
    localparam logic [1:0] DIV_END    = 2'b11;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_sign_fix.sv
// rtl/div_sign_fix.sv - combinational two's-complement negate-and-select (abs at start, fix-up at end)
module div_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value_i,
    input  logic         negate_i,
    output logic [W-1:0] value_o
);

    assign value_o = negate_i ? ((~value_i) + W'(1)) : value_i;

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - radix-2 shift-subtract DIV/DIVU unit, result {remainder, quotient}
// Optional STPU_DIV_ZERO_FLAG_EN adds div_zero_o alongside ready_o.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
`ifdef STPU_DIV_ZERO_FLAG_EN
    ,
    output logic                  div_zero_o
`endif
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   dvd_q, dvd_d;
    logic [DATA_W-1:0]   dsr_q, dsr_d;
    logic                sign1_q, sign1_d;
    logic                sign2_q, sign2_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;
    logic                zero_q, zero_d;

    logic                op1_neg, op2_neg;
    logic [DATA_W-1:0]   op1_abs, op2_abs;
    logic [DATA_W:0]     rem_sh, diff;
    logic [DATA_W-1:0]   rem_nx, quo_nx, rem_fix, quo_fix;

    assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
    assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];

    div_sign_fix #(.W(DATA_W)) u_abs1 (.value_i(opdata1_i), .negate_i(op1_neg), .value_o(op1_abs));
    div_sign_fix #(.W(DATA_W)) u_abs2 (.value_i(opdata2_i), .negate_i(op2_neg), .value_o(op2_abs));

    // DATA_W+1-bit subtract: the top bit is the borrow, i.e. rem < divisor
    assign rem_sh = {rem_q, dvd_q[DATA_W-1]};
    assign diff   = rem_sh - {1'b0, dsr_q};
    assign rem_nx = diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
    assign quo_nx = {dvd_q[DATA_W-2:0], ~diff[DATA_W]};

    div_sign_fix #(.W(DATA_W)) u_fix_q (.value_i(quo_nx), .negate_i(sign1_q ^ sign2_q), .value_o(quo_fix));
    div_sign_fix #(.W(DATA_W)) u_fix_r (.value_i(rem_nx), .negate_i(sign1_q), .value_o(rem_fix));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        result_d = result_q;
        ready_d  = ready_q;
        zero_d   = zero_q;
        case (state_q)
            DIV_FREE: begin
                ready_d  = DIV_RESULT_NOT_READY;
                result_d = '0;
                zero_d   = 1'b0;
                if (start_i && !annul_i) begin
                    cnt_d   = '0;
                    sign1_d = op1_neg;
                    sign2_d = op2_neg;
                    if (opdata2_i == '0) begin
                        state_d = DIV_BYZERO;
                        dvd_d   = opdata1_i;
                    end else begin
                        state_d = DIV_ON;
                        rem_d   = '0;
                        dvd_d   = op1_abs;
                        dsr_d   = op2_abs;
                    end
                end
            end
            DIV_BYZERO: begin
                state_d  = DIV_END;
                ready_d  = DIV_RESULT_READY;
                result_d = {dvd_q, {DATA_W{1'b1}}};
                zero_d   = 1'b1;
            end
            DIV_ON: begin
                rem_d = rem_nx;
                dvd_d = quo_nx;
                cnt_d = cnt_q + CNT_W'(1);
                // Final iteration registers the sign-corrected result directly
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d  = DIV_END;
                    ready_d  = DIV_RESULT_READY;
                    result_d = {rem_fix, quo_fix};
                end
            end
            default: begin
                if (!start_i) begin
                    state_d  = DIV_FREE;
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = '0;
                    zero_d   = 1'b0;
                end
            end
        endcase
        if (annul_i && (state_q != DIV_FREE)) begin
            state_d  = DIV_FREE;
            ready_d  = DIV_RESULT_NOT_READY;
            result_d = '0;
            zero_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DIV_FREE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= DIV_RESULT_NOT_READY;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dsr_q    <= dsr_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            zero_q   <= zero_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
`ifdef STPU_DIV_ZERO_FLAG_EN
    assign div_zero_o = zero_q;
`else
    logic unused_zero;
    assign unused_zero = zero_q;
`endif

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - table-driven scoreboard bench for div_unit
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
`ifdef STPU_DIV_ZERO_FLAG_EN
    logic        div_zero_o;
`endif

    div_unit #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
`ifdef STPU_DIV_ZERO_FLAG_EN
        ,
        .div_zero_o   (div_zero_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] exp_q[$];
    int          lat_q[$];
    bit          zf_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string name);
        int          lat;
        bit          seen;
        logic [63:0] e;
        int          el;
        bit          ez;
        exp_q.push_back(exp);
        lat_q.push_back((b == 32'd0) ? 2 : 33);
        zf_q.push_back(b == 32'd0);
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk);
        #1;
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (ready_o) begin
                lat  = k + 1;
                seen = 1'b1;
                break;
            end
        end
        e  = exp_q.pop_front();
        el = lat_q.pop_front();
        ez = zf_q.pop_front();
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: ready_o never rose, expected result %h", name, e);
        end else begin
            check({name, " latency"}, 64'(lat), 64'(el));
            check({name, " result"}, result_o, e);
`ifdef STPU_DIV_ZERO_FLAG_EN
            check({name, " div_zero"}, 64'(div_zero_o), 64'(ez));
`endif
            @(posedge clk);
            #1;
            check({name, " hold ready"}, 64'(ready_o), 64'd1);
            check({name, " hold result"}, result_o, e);
        end
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({name, " release ready"}, 64'(ready_o), 64'd0);
        check({name, " release result"}, result_o, 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
        start_i = 1'b0; annul_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 64'(ready_o), 64'd0);
        check("reset result", result_o, 64'd0);
`ifdef STPU_DIV_ZERO_FLAG_EN
        check("reset div_zero", 64'(div_zero_o), 64'd0);
`endif
        rst = 1'b0;

        vecs.push_back('{1'b0, 32'd100,        32'd7,          {32'd2,          32'd14}});
        vecs.push_back('{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF,  32'hFFFF_FFFD}});
        vecs.push_back('{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1,          32'hFFFF_FFFD}});
        vecs.push_back('{1'b0, 32'd5,          32'd0,          {32'd5,          32'hFFFF_FFFF}});
        vecs.push_back('{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0,          32'h8000_0000}});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'h10,         {32'hF,          32'h0FFF_FFFF}});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'd0,          32'hFFFF_FFFF}});
        vecs.push_back('{1'b0, 32'd3,          32'd7,          {32'd3,          32'd0}});
        vecs.push_back('{1'b1, 32'hFFFF_FFF8,  32'd0,          {32'hFFFF_FFF8,  32'hFFFF_FFFF}});
        vecs.push_back('{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  {32'hFFFF_FFFE,  32'h0000_000E}});
        vecs.push_back('{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000,  32'd0}});
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom_range(1, 32'hFFFF);
            vecs.push_back('{1'b0, ra, rb, {ra % rb, ra / rb}});
        end

        for (int i = 0; i < vecs.size(); i++)
            do_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

        // annul after 10 iterations, then an immediate new start
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        check("annul ready", 64'(ready_o), 64'd0);
        check("annul result", result_o, 64'd0);
        annul_i = 1'b0;
        do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, "after_annul");

        // synchronous reset in the middle of a division
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'hFFFF_FFFF; opdata2_i = 32'h10; start_i = 1'b1;
        @(posedge clk);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst ready", 64'(ready_o), 64'd0);
        check("midrst result", result_o, 64'd0);
        rst = 1'b0;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("postrst ready", 64'(ready_o), 64'd0);
        do_div(1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
